uart_boot_loader: RTL

Parametrised UART boot loader for the Ottochip family. After reset it measures the host baud rate from a 0xFF sync byte, hunts for a magic word, and receives a word count. It then streams that many payload words into program memory through a valid/ready write port and checks a trailing additive checksum. It sits between the `io_pad` UART RX pin and the instruction-memory write port, and holds the core in reset until `done`.

---
 rtl/uart_boot_loader_if.sv | 26 ++
 rtl/uart_boot_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader_if.sv
// Instruction-memory write port used by the boot loader: valid/ready with address and data.
interface uart_boot_loader_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Boot loader side issues writes.
  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  // Memory side accepts writes.
  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: auto-bauds on a 0xFF sync byte, hunts for a magic word, reads a
// word count, streams that many words to program memory and verifies an additive checksum.
module uart_boot_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned MAX_WORDS  = 1024,
  parameter logic [31:0] MAGIC      = 32'h43414645,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  uart_boot_loader_if.master   mem,
  output logic [DIV_WIDTH-1:0] bit_period,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned IDX_W  = $clog2(MAX_WORDS + 1);
  localparam logic [DATA_WIDTH-1:0] MagicWord = DATA_WIDTH'(MAGIC);

  typedef enum logic [3:0] {
    StAbWait, StAbMeas, StMagic, StLength, StPayload, StWrite, StCheck, StDone, StError
  } state_e;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  state_e    state_q, state_d;
  rx_state_e rx_state_q, rx_state_d;

  logic                  rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DIV_WIDTH-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]            rx_bit_q, rx_bit_d;
  logic [7:0]            rx_shift_q, rx_shift_d;
  logic [DIV_WIDTH-1:0]  ab_cnt_q, ab_cnt_d;
  logic [DIV_WIDTH-1:0]  bit_period_q, bit_period_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [IDX_W-1:0]      len_q, len_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  rx_fall;
  logic                  rx_en;
  logic                  byte_valid;
  logic                  frame_err;
  logic                  word_full;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] word_next;

  assign rx_fall   = rx_prev_q & ~rx_sync_q;
  assign rx_en     = (state_q == StMagic) || (state_q == StLength) || (state_q == StPayload) ||
                     (state_q == StWrite) || (state_q == StCheck);
  assign word_next = (word_q << 8) | DATA_WIDTH'(rx_shift_q);
  assign word_full = byte_valid && (bcnt_q == BCNT_W'(BYTES - 1));
  assign handshake = mem_valid_q && mem.mem_ready;

  // State register and all datapath flops; asynchronous reset to load-start values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StAbWait;
      rx_state_q   <= RxIdle;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      ab_cnt_q     <= '0;
      bit_period_q <= '0;
      word_q       <= '0;
      bcnt_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= ADDR_WIDTH'(BASE_ADDR);
      mem_wdata_q  <= '0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_state_q   <= rx_state_d;
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      ab_cnt_q     <= ab_cnt_d;
      bit_period_q <= bit_period_d;
      word_q       <= word_d;
      bcnt_q       <= bcnt_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Byte receiver: mid-bit sampling timed from the start-bit falling edge.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (!rx_en) begin
      rx_state_d = RxIdle;
    end else begin
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_fall) begin
            rx_state_d = RxStart;
            rx_cnt_d   = DIV_WIDTH'(1);
          end
        end
        RxStart: begin
          if (rx_cnt_q >= (bit_period_q >> 1)) begin
            // Line back high at mid start bit means a spike, not a frame.
            rx_state_d = rx_sync_q ? RxIdle : RxData;
            rx_cnt_d   = DIV_WIDTH'(1);
            rx_bit_d   = '0;
          end else begin
            rx_cnt_d = rx_cnt_q + DIV_WIDTH'(1);
          end
        end
        RxData: begin
          if (rx_cnt_q >= bit_period_q) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_cnt_d   = DIV_WIDTH'(1);
            if (rx_bit_q == 3'd7) rx_state_d = RxStop;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_cnt_d = rx_cnt_q + DIV_WIDTH'(1);
          end
        end
        RxStop: begin
          if (rx_cnt_q >= bit_period_q) begin
            byte_valid = rx_sync_q;
            frame_err  = ~rx_sync_q;
            rx_state_d = RxIdle;
          end else begin
            rx_cnt_d = rx_cnt_q + DIV_WIDTH'(1);
          end
        end
      endcase
    end
  end

  // Main FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StAbWait: if (rx_fall) state_d = StAbMeas;
      StAbMeas: begin
        if (rx_sync_q) state_d = (ab_cnt_q < DIV_WIDTH'(8)) ? StAbWait : StMagic;
        else if (ab_cnt_q == '1) state_d = StError;
      end
      StMagic: begin
        if (frame_err) state_d = StError;
        else if (byte_valid && (word_next == MagicWord)) state_d = StLength;
      end
      StLength: begin
        if (frame_err) state_d = StError;
        else if (word_full) begin
          if (word_next > DATA_WIDTH'(MAX_WORDS)) state_d = StError;
          else if (word_next == '0)              state_d = StCheck;
          else                                   state_d = StPayload;
        end
      end
      StPayload: begin
        if (frame_err)      state_d = StError;
        else if (word_full) state_d = StWrite;
      end
      StWrite: begin
        // A word completing while a write is still pending has nowhere to go: overrun.
        if (frame_err || word_full) state_d = StError;
        else if (handshake) state_d = (idx_q + IDX_W'(1) == len_q) ? StCheck : StPayload;
      end
      StCheck: begin
        if (frame_err) state_d = StError;
        else if (word_full) state_d = (word_next == csum_q) ? StDone : StError;
      end
      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StError;
    endcase
  end

  // Datapath and registered outputs, steered by the current and next main state.
  always_comb begin
    ab_cnt_d     = ab_cnt_q;
    bit_period_d = bit_period_q;
    word_d       = word_q;
    bcnt_d       = bcnt_q;
    len_d        = len_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    if (state_q == StAbWait && rx_fall) ab_cnt_d = DIV_WIDTH'(1);
    if (state_q == StAbMeas) begin
      if (rx_sync_q)             bit_period_d = ab_cnt_q;
      else if (ab_cnt_q != '1)   ab_cnt_d     = ab_cnt_q + DIV_WIDTH'(1);
    end

    if (byte_valid) begin
      word_d = word_next;
      bcnt_d = word_full ? '0 : bcnt_q + BCNT_W'(1);
    end
    // Magic hunt is a sliding window, so word alignment starts after it.
    if (state_q == StMagic) bcnt_d = '0;

    if (state_q == StLength && word_full) begin
      len_d  = word_next[IDX_W-1:0];
      idx_d  = '0;
      csum_d = '0;
    end

    if (state_q == StPayload && word_full) begin
      mem_wdata_d = word_next;
      mem_addr_d  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(BYTES) * ADDR_WIDTH'(idx_q);
      mem_valid_d = 1'b1;
      csum_d      = csum_q + word_next;
    end

    if (state_q == StWrite && handshake) begin
      mem_valid_d = 1'b0;
      idx_d       = idx_q + IDX_W'(1);
    end

    if (state_d == StDone || state_d == StError) mem_valid_d = 1'b0;

    busy_d  = (state_d != StDone) && (state_d != StError);
    done_d  = done_q  | (state_d == StDone);
    error_d = error_q | (state_d == StError);
  end

  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign bit_period    = bit_period_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule
